serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor for WIDTH-bit operands; processes SLICE bits per clock, LSB slice first.
- The carry ripples through a carry register between slices.
- Used wherever area matters more than latency; the structural full-adder cell is reused per slice bit.
- Start/busy/done handshake with registered, held results and sum flags: carryout, overflow, zero.

---
 rtl/serial_adder.sv | 160 ++++++++++++++++
 tb/tb_serial_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor. WIDTH-bit operands are added SLICE bits per
//   clock, least-significant slice first, with the carry held in a register
//   between slices. A start/busy/done handshake frames each operation; the
//   result and its flags stay registered until the next accepted start.
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request, sampled only in IDLE or DONE
//   a         in   WIDTH  operand A, captured on the accepting edge
//   b         in   WIDTH  operand B, captured on the accepting edge
//   carryin   in   1      initial carry (ignored when sub=1)
//   sub       in   1      0: a+b+carryin, 1: a-b (a + ~b + 1)
//   busy      out  1      high while slices are being computed
//   done      out  1      one-cycle pulse, result valid
//   sum       out  WIDTH  result
//   carryout  out  1      carry out of the MSB (for sub: 1 = no borrow)
//   overflow  out  1      two's-complement overflow
//   zero      out  1      sum == 0
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = (SLICE > 0) ? (WIDTH / SLICE) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Parameter legality is checked at elaboration.
    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("serial_adder: SLICE must be at least 1");
        end else if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder: WIDTH must be at least 2");
        end else if ((WIDTH % SLICE) != 0) begin : g_bad_div
            $error("serial_adder: SLICE must divide WIDTH exactly");
        end
    endgenerate

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // Ripple a slice through the full-adder cell.
    // Returns {carry into top bit, carry out of top bit, slice sum}.
    function automatic logic [SLICE+1:0] add_slice(input logic [SLICE-1:0] x,
                                                   input logic [SLICE-1:0] y,
                                                   input logic             ci);
        logic             cc;
        logic             c_top_in;
        logic [1:0]       fa;
        logic [SLICE-1:0] s;
        cc       = ci;
        c_top_in = ci;
        s        = '0;
        for (int i = 0; i < SLICE; i++) begin
            c_top_in = cc;
            fa       = full_add(x[i], y[i], cc);
            s[i]     = fa[0];
            cc       = fa[1];
        end
        return {c_top_in, cc, s};
    endfunction

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE+1:0] slice_res;
    logic [SLICE-1:0] slice_sum;
    logic             slice_co;
    logic             slice_c_top;
    logic [WIDTH-1:0] sum_next;
    logic             last;

    always_comb begin
        slice_a     = SLICE'(op_a >> (cnt * SLICE));
        slice_b     = SLICE'(op_b >> (cnt * SLICE));
        slice_res   = add_slice(slice_a, slice_b, carry);
        slice_sum   = slice_res[SLICE-1:0];
        slice_co    = slice_res[SLICE];
        slice_c_top = slice_res[SLICE+1];
        // Sum with the current slice merged in; on the last slice this is the
        // final result, which lets zero be registered on the same edge.
        sum_next                      = sum;
        sum_next[cnt*SLICE +: SLICE]  = slice_sum;
        last                          = (cnt == CNT_W'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and force carry-in.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : carryin;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum   <= sum_next;
                    carry <= slice_co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        carryout <= slice_co;
                        overflow <= slice_co ^ slice_c_top;
                        zero     <= (sum_next == '0);
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Drives four serial_adder instances (8x1, 8x4, 4x1, 4x2 as WIDTH x SLICE)
//   from shared inputs and compares them against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       carryin;
    logic       sub;

    wire  [3:0] busy_v;
    wire  [3:0] done_v;
    wire  [3:0] cout_v;
    wire  [3:0] ovf_v;
    wire  [3:0] zero_v;
    wire  [7:0] s0;
    wire  [7:0] s1;
    wire  [3:0] s2;
    wire  [3:0] s3;
    logic [7:0] sum_v [4];

    int n_cmp = 0;
    int n_err = 0;

    int wid [4] = '{8, 8, 4, 4};
    int nsl [4] = '{8, 2, 4, 2};

    always_comb begin
        sum_v[0] = s0;
        sum_v[1] = s1;
        sum_v[2] = {4'd0, s2};
        sum_v[3] = {4'd0, s3};
    end

    serial_adder #(.WIDTH(8), .SLICE(1)) u_8x1 (
        .clk(clk), .reset(reset), .start(start), .a(a8), .b(b8),
        .carryin(carryin), .sub(sub), .busy(busy_v[0]), .done(done_v[0]),
        .sum(s0), .carryout(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]));

    serial_adder #(.WIDTH(8), .SLICE(4)) u_8x4 (
        .clk(clk), .reset(reset), .start(start), .a(a8), .b(b8),
        .carryin(carryin), .sub(sub), .busy(busy_v[1]), .done(done_v[1]),
        .sum(s1), .carryout(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]));

    serial_adder #(.WIDTH(4), .SLICE(1)) u_4x1 (
        .clk(clk), .reset(reset), .start(start), .a(a8[3:0]), .b(b8[3:0]),
        .carryin(carryin), .sub(sub), .busy(busy_v[2]), .done(done_v[2]),
        .sum(s2), .carryout(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]));

    serial_adder #(.WIDTH(4), .SLICE(2)) u_4x2 (
        .clk(clk), .reset(reset), .start(start), .a(a8[3:0]), .b(b8[3:0]),
        .carryin(carryin), .sub(sub), .busy(busy_v[3]), .done(done_v[3]),
        .sum(s3), .carryout(cout_v[3]), .overflow(ovf_v[3]), .zero(zero_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {overflow, zero, carryout, sum[7:0]}.
    function automatic logic [10:0] ref_model(input int w, input logic [7:0] av,
                                              input logic [7:0] bv, input logic cv,
                                              input logic sv);
        int mask, ai, be, ci, full, s, co, ov, z;
        mask = (1 << w) - 1;
        ai   = int'(av) & mask;
        be   = sv ? ((~int'(bv)) & mask) : (int'(bv) & mask);
        ci   = sv ? 1 : int'(cv);
        full = ai + be + ci;
        s    = full & mask;
        co   = (full >> w) & 1;
        // Signed overflow: both addends share a sign that the result lacks.
        ov   = ((((ai >> (w-1)) & 1) == ((be >> (w-1)) & 1)) &&
                (((s >> (w-1)) & 1) != ((ai >> (w-1)) & 1))) ? 1 : 0;
        z    = (s == 0) ? 1 : 0;
        return {ov[0], z[0], co[0], s[7:0]};
    endfunction

    // One operation on all instances: timing of busy/done plus held results.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic sv);
        int          first_done [4];
        int          n_done     [4];
        int          n_busy     [4];
        logic [10:0] e;
        a8 = av; b8 = bv; carryin = cv; sub = sv; start = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after the accepting edge; they must not matter.
        start   = 1'b0;
        a8      = 8'($urandom);
        b8      = 8'($urandom);
        carryin = 1'($urandom);
        sub     = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            first_done[i] = -1; n_done[i] = 0; n_busy[i] = 0;
        end
        for (int cyc = 0; cyc <= 10; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (busy_v[i]) n_busy[i]++;
                if (done_v[i]) begin
                    n_done[i]++;
                    if (first_done[i] < 0) first_done[i] = cyc;
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            e = ref_model(wid[i], av, bv, cv, sv);
            check($sformatf("lat[%0d] a=%h b=%h", i, av, bv), first_done[i], nsl[i]);
            check($sformatf("ndone[%0d]", i), n_done[i], 1);
            check($sformatf("nbusy[%0d]", i), n_busy[i], nsl[i]);
            check($sformatf("sum[%0d] a=%h b=%h c=%0d s=%0d", i, av, bv, cv, sv),
                  sum_v[i], e[7:0]);
            check($sformatf("cout[%0d] a=%h b=%h c=%0d s=%0d", i, av, bv, cv, sv),
                  cout_v[i], e[8]);
            check($sformatf("zero[%0d] a=%h b=%h c=%0d s=%0d", i, av, bv, cv, sv),
                  zero_v[i], e[9]);
            check($sformatf("ovf[%0d] a=%h b=%h c=%0d s=%0d", i, av, bv, cv, sv),
                  ovf_v[i], e[10]);
        end
    endtask

    initial begin
        logic [10:0] ex;
        logic [7:0]  xa, xb, ya, yb;
        int          n_done_rst;

        reset = 1'b1; start = 1'b0; a8 = '0; b8 = '0; carryin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_v, 4'h0);
        check("rst_done", done_v, 4'h0);
        check("rst_cout", cout_v, 4'h0);
        check("rst_ovf", ovf_v, 4'h0);
        check("rst_zero", zero_v, 4'h0);
        check("rst_sum0", sum_v[0], 8'h00);
        check("rst_sum1", sum_v[1], 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-computed 8-bit results (instance 8x1).
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        check("d_ff01_sum", sum_v[0], 8'h00);
        check("d_ff01_cout", cout_v[0], 1'b1);
        check("d_ff01_ovf", ovf_v[0], 1'b0);
        check("d_ff01_zero", zero_v[0], 1'b1);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        check("d_7f01_sum", sum_v[0], 8'h80);
        check("d_7f01_ovf", ovf_v[0], 1'b1);
        check("d_7f01_zero", zero_v[0], 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 1'b0);
        check("d_8080_sum", sum_v[0], 8'h00);
        check("d_8080_cout", cout_v[0], 1'b1);
        check("d_8080_ovf", ovf_v[0], 1'b1);
        do_op(8'h05, 8'h07, 1'b1, 1'b1);
        check("d_sub57_sum", sum_v[0], 8'hFE);
        check("d_sub57_cout", cout_v[0], 1'b0);
        check("d_sub57_ovf", ovf_v[0], 1'b0);
        do_op(8'h07, 8'h05, 1'b1, 1'b1);
        check("d_sub75_sum", sum_v[0], 8'h02);
        check("d_sub75_cout", cout_v[0], 1'b1);
        do_op(8'h3C, 8'hC5, 1'b1, 1'b0);
        check("d_3cc5_sum4", sum_v[1], 8'h02);
        check("d_3cc5_cout4", cout_v[1], 1'b1);

        // Back-to-back on the 8x4 instance: start held high, new operands
        // applied right after the first accept.
        xa = 8'($urandom); xb = 8'($urandom); ya = 8'($urandom); yb = 8'($urandom);
        a8 = xa; b8 = xb; carryin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a8 = ya; b8 = yb; sub = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_done c%0d", cyc), done_v[1], ((cyc % 3) == 2) ? 1'b1 : 1'b0);
            check($sformatf("b2b_busy c%0d", cyc), busy_v[1], ((cyc % 3) != 2) ? 1'b1 : 1'b0);
            if (cyc == 2) begin
                ex = ref_model(8, xa, xb, 1'b0, 1'b0);
                check("b2b_sum1", sum_v[1], ex[7:0]);
                check("b2b_cout1", cout_v[1], ex[8]);
            end
            if (cyc == 5) begin
                ex = ref_model(8, ya, yb, 1'b0, 1'b1);
                check("b2b_sum2", sum_v[1], ex[7:0]);
                check("b2b_cout2", cout_v[1], ex[8]);
                check("b2b_ovf2", ovf_v[1], ex[10]);
            end
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Reset in the middle of a run; start asserted with reset is ignored.
        a8 = 8'h5A; b8 = 8'h33; carryin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy_before", busy_v[0], 1'b1);
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy_v, 4'h0);
        check("mid_rst_done", done_v, 4'h0);
        check("mid_rst_sum0", sum_v[0], 8'h00);
        check("mid_rst_sum1", sum_v[1], 8'h00);
        reset = 1'b0; start = 1'b0;
        n_done_rst = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (done_v != 4'h0 || busy_v != 4'h0) n_done_rst++;
        end
        check("mid_rst_quiet", n_done_rst, 0);
        do_op(8'h5A, 8'h33, 1'b0, 1'b0);
        check("mid_rst_fresh_sum", sum_v[0], 8'h8D);

        // Exhaustive over 4-bit operands, carryin and sub; the upper nibble is
        // random so the 8-bit instances see random operands at the same time.
        for (int sv = 0; sv < 2; sv++) begin
            for (int cv = 0; cv < 2; cv++) begin
                for (int av = 0; av < 16; av++) begin
                    for (int bv = 0; bv < 16; bv++) begin
                        logic [3:0] ha, hb;
                        ha = 4'($urandom);
                        hb = 4'($urandom);
                        do_op({ha, 4'(av)}, {hb, 4'(bv)}, 1'(cv), 1'(sv));
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
